regfile_wb_ctrl: RTL

Write-side controller for the 32-entry, x0-hardwired register file. It merges ALU results and multi-cycle load results into the register file's single write port (`reg_write`/`waddr`/`wdata`) and queues load results in a small FIFO. It also keeps a per-register pending-load scoreboard so decode can detect read-after-load hazards on both read ports.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/regfile_wb_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and helpers for the register-file write side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int N_REG      = 32;
    localparam int REG_ADDR_W = 5;

    // One-hot register select; x0 is hardwired and never gets a bit.
    function automatic logic [N_REG-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [N_REG-1:0] v;
        v = '0;
        if (addr != '0) v[addr] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous single-clock FIFO holding pending load results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Storage is left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
    end

    // Power-of-2 depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
// ============================================================================
// Module      : regfile_wb_ctrl
// Description : Merges ALU and load results onto the register-file write port
//               and tracks pending loads. REGFILE_WB_BYPASS_EN lets a load
//               skip the empty FIFO when the port is idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_waddr,
    input  logic [DATA_W-1:0]     alu_wdata,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [4:0]            mem_waddr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  load_issue,
    input  logic [4:0]            load_issue_addr,
    input  logic [4:0]            raddr_1,
    input  logic [4:0]            raddr_2,
    output logic                  haz_1,
    output logic                  haz_2,
    output logic [31:0]           pend_mask,
    output logic                  reg_write,
    output logic [4:0]            waddr,
    output logic [DATA_W-1:0]     wdata
);

    // Declared here because its data width comes from this instance.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_req_t              w_mem_req;
    wb_req_t              w_head;
    wb_req_t              w_sel;
    logic                 w_sel_valid;
    logic                 w_sel_load;
    logic                 w_mem_acc;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic [N_REG-1:0]     w_pend_set;
    logic [N_REG-1:0]     w_pend_clr;

    logic                 r_reg_write;
    logic [4:0]           r_waddr;
    logic [DATA_W-1:0]    r_wdata;
    logic [N_REG-1:0]     r_pend;

    assign w_mem_req = '{addr: mem_waddr, data: mem_wdata};
    assign mem_ready = ~srst & (w_count < c_CNT_W'(FIFO_DEPTH));
    assign w_mem_acc = mem_valid & mem_ready;

`ifdef REGFILE_WB_BYPASS_EN
    assign w_bypass = w_mem_acc & w_empty & ~alu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_mem_acc & ~w_bypass;
    assign w_pop  = ~alu_valid & ~w_empty;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wb_req_t))
    ) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_mem_req),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // ALU owns the port; otherwise the FIFO head, otherwise a bypassed load.
    always_comb begin
        w_sel       = '0;
        w_sel_valid = 1'b0;
        w_sel_load  = 1'b0;
        if (alu_valid) begin
            w_sel       = '{addr: alu_waddr, data: alu_wdata};
            w_sel_valid = 1'b1;
        end else if (w_pop) begin
            w_sel       = w_head;
            w_sel_valid = 1'b1;
            w_sel_load  = 1'b1;
        end else if (w_bypass) begin
            w_sel       = w_mem_req;
            w_sel_valid = 1'b1;
            w_sel_load  = 1'b1;
        end
    end

    assign w_pend_set = load_issue ? reg_onehot(load_issue_addr) : '0;
    assign w_pend_clr = w_sel_load ? reg_onehot(w_sel.addr) : '0;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_reg_write <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_pend      <= '0;
        end else begin
            // x0 writes are consumed but never reach the register file.
            r_reg_write <= w_sel_valid & (w_sel.addr != '0);
            if (w_sel_valid) begin
                r_waddr <= w_sel.addr;
                r_wdata <= w_sel.data;
            end
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

    assign reg_write = r_reg_write;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign pend_mask = r_pend;
    assign haz_1     = r_pend[raddr_1] & (raddr_1 != '0);
    assign haz_2     = r_pend[raddr_2] & (raddr_2 != '0);

endmodule

`default_nettype wire
